// File: rtl/cpu_types.sv
// Shared CPU types: reservation-station tag, common data bus payload.
package cpu_types;
  localparam int NUM_CDB_REQ = 4;
  localparam int TAG_W       = 4;

  typedef logic [TAG_W-1:0] RS_tag_type;
  localparam RS_tag_type INVALID = '0;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: one-hot grant to the first active
// index at or after ptr, wrapping NUM_REQ-1 -> 0.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);
  logic             found;
  logic [PTR_W-1:0] idx;
  int               sum;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (!found && active[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among result producers,
// registered broadcast, and per-requester starvation counters.
module cdb_arbiter
  import cpu_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int WAIT_W  = 4
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic       [NUM_REQ-1:0]        REQ_VALID,
  input  RS_tag_type [NUM_REQ-1:0]        REQ_TAG,
  input  logic       [NUM_REQ-1:0][31:0]  REQ_DATA,
  input  logic                            FLUSH,
  output logic       [NUM_REQ-1:0]        GRANT,
  output cdb_t                            CDB_OUT,
  output logic       [WAIT_W-1:0]         MAX_WAIT
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  logic [PTR_W-1:0]                ptr_q, ptr_d;
  logic [NUM_REQ-1:0][WAIT_W-1:0]  wait_q, wait_d;
  logic [WAIT_W-1:0]               max_wait_q, max_wait_d;
  cdb_t                            cdb_q, cdb_d;

  logic [NUM_REQ-1:0] active;
  logic [PTR_W-1:0]   win;

  // Reset gating here keeps GRANT low for the whole reset window.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_REQ; i++)
      active[i] = REQ_VALID[i] && (REQ_TAG[i] != INVALID) && !FLUSH && RST_N;
  end

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .active (active),
    .ptr    (ptr_q),
    .grant  (GRANT)
  );

  always_comb begin
    win   = '0;
    cdb_d = '{tag: INVALID, data: 32'h0};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT[i]) begin
        win   = PTR_W'(i);
        cdb_d = '{tag: REQ_TAG[i], data: REQ_DATA[i]};
      end
    end
    ptr_d = ptr_q;
    if (|GRANT)
      ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
  end

  // Inactive or granted requesters restart their wait from zero.
  always_comb begin
    wait_d     = '0;
    max_wait_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active[i] && !GRANT[i])
        wait_d[i] = (wait_q[i] == WAIT_SAT) ? wait_q[i] : wait_q[i] + 1'b1;
      if (wait_d[i] > max_wait_d)
        max_wait_d = wait_d[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q      <= '0;
      wait_q     <= '0;
      max_wait_q <= '0;
      cdb_q      <= '{tag: INVALID, data: 32'h0};
    end else begin
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      max_wait_q <= max_wait_d;
      cdb_q      <= cdb_d;
    end
  end

  assign CDB_OUT  = cdb_q;
  assign MAX_WAIT = max_wait_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized bench for cdb_arbiter against a queue-free
// per-cycle reference model of the round-robin rules.
module tb_cdb_arbiter;
  import cpu_types::*;

  localparam int N      = 4;
  localparam int WAIT_W = 4;
  localparam int WMAX   = (1 << WAIT_W) - 1;

  logic                       CLK = 1'b0;
  logic                       RST_N;
  logic       [N-1:0]         REQ_VALID;
  RS_tag_type [N-1:0]         REQ_TAG;
  logic       [N-1:0][31:0]   REQ_DATA;
  logic                       FLUSH;
  logic       [N-1:0]         GRANT;
  cdb_t                       CDB_OUT;
  logic       [WAIT_W-1:0]    MAX_WAIT;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_ptr;
  int         m_wait [N];
  RS_tag_type m_tag;
  logic [31:0] m_data;
  int         m_max;

  cdb_arbiter #(.NUM_REQ(N), .WAIT_W(WAIT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_TAG(REQ_TAG),
    .REQ_DATA(REQ_DATA), .FLUSH(FLUSH), .GRANT(GRANT), .CDB_OUT(CDB_OUT),
    .MAX_WAIT(MAX_WAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_tag = INVALID; m_data = 32'h0; m_max = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  function automatic bit is_active(input int i);
    return REQ_VALID[i] && (REQ_TAG[i] != INVALID) && !FLUSH && RST_N;
  endfunction

  // Winner = first active index walking upward from the pointer, or -1.
  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (is_active((m_ptr + k) % N)) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Inputs must already be applied; returns one edge later at edge+1.
  task automatic step(input string nm);
    int w;
    logic [N-1:0] eg;
    bit act [N];
    w  = pick();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    for (int i = 0; i < N; i++) act[i] = is_active(i);
    #1;
    chk({nm, "_grant"}, 64'(GRANT), 64'(eg));
    @(posedge CLK);
    if (w >= 0) begin
      m_tag  = REQ_TAG[w];
      m_data = REQ_DATA[w];
      m_ptr  = (w + 1) % N;
    end else begin
      m_tag  = INVALID;
      m_data = 32'h0;
    end
    m_max = 0;
    for (int i = 0; i < N; i++) begin
      if (act[i] && i != w) m_wait[i] = (m_wait[i] < WMAX) ? m_wait[i] + 1 : WMAX;
      else                  m_wait[i] = 0;
      if (m_wait[i] > m_max) m_max = m_wait[i];
    end
    #1;
    chk({nm, "_cdb"}, 64'(CDB_OUT), {28'h0, m_tag, m_data});
    chk({nm, "_maxw"}, 64'(MAX_WAIT), 64'(m_max));
  endtask

  task automatic drive(input logic [N-1:0] v, input bit fl);
    REQ_VALID = v;
    FLUSH     = fl;
    for (int i = 0; i < N; i++) begin
      REQ_TAG[i]  = RS_tag_type'(i + 1);
      REQ_DATA[i] = 32'hA000_0000 + 32'(i);
    end
  endtask

  initial begin
    model_reset();
    RST_N = 1'b0;
    drive(4'b1111, 1'b0);
    #2;
    chk("rst_grant", 64'(GRANT), 64'h0);
    chk("rst_cdb", 64'(CDB_OUT), 64'h0);
    chk("rst_maxw", 64'(MAX_WAIT), 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // full contention from PTR=0: order 0,1,2,3,0,1,2,3
    for (int c = 0; c < 8; c++) step($sformatf("rr%0d", c));
    chk("rr_maxw3", 64'(MAX_WAIT), 64'd3);

    // single requester with a specific tag/data
    drive(4'b0100, 1'b0);
    REQ_TAG[2]  = RS_tag_type'(5);
    REQ_DATA[2] = 32'hDEAD_BEEF;
    step("single");
    chk("single_cdb", 64'(CDB_OUT), {28'h0, 4'h5, 32'hDEAD_BEEF});

    // wrap: PTR=3 with 1001 -> 3 then 0, then PTR=1 seen via 1111
    drive(4'b1001, 1'b0);
    step("wrap3");
    step("wrap0");
    drive(4'b1111, 1'b0);
    step("wrap_ptr1");

    // flush suppresses one cycle then grants resume
    drive(4'b0011, 1'b1);
    step("flush");
    drive(4'b0011, 1'b0);
    step("post_flush");

    // invalid tag never counts as active
    drive(4'b0010, 1'b0);
    REQ_TAG[1] = INVALID;
    step("badtag");
    step("badtag2");

    // randomized traffic
    for (int c = 0; c < 300; c++) begin
      REQ_VALID = N'($urandom);
      FLUSH     = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        REQ_TAG[i]  = ($urandom_range(0, 7) == 0) ? INVALID : RS_tag_type'($urandom_range(1, 15));
        REQ_DATA[i] = $urandom;
      end
      step($sformatf("rnd%0d", c));
    end

    // asynchronous reset mid-stream, then first grant goes to index 0
    drive(4'b1111, 1'b0);
    step("pre_rst0");
    step("pre_rst1");
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("arst_cdb", 64'(CDB_OUT), 64'h0);
    chk("arst_grant", 64'(GRANT), 64'h0);
    chk("arst_maxw", 64'(MAX_WAIT), 64'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    step("post_rst");
    chk("post_rst_idx0", 64'(CDB_OUT), {28'h0, 4'h1, 32'hA000_0000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of result producers: index 0 LOAD_1, 1 LOAD_2, 2 ALU_1, 3 ALU_2.
REQ-002 SHALL have parameter WAIT_W, default 4, meaning the width of each per-requester wait counter.
REQ-003 SHALL have CLK  input  1  system clock, rising edge.
REQ-004 SHALL have RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have REQ_VALID  input  NUM_REQ  per-requester result-ready flag.
REQ-006 SHALL have REQ_TAG  input  NUM_REQ x RS_tag_type  per-requester destination tag.
REQ-007 SHALL have REQ_DATA  input  NUM_REQ x 32  per-requester result value.
REQ-008 SHALL have FLUSH  input  1  pipeline flush, suppresses grants this cycle.
REQ-009 SHALL have GRANT  output  NUM_REQ  one-hot accept, combinational, same cycle as request.
REQ-010 SHALL have CDB_OUT  output  cdb_t  registered broadcast {tag, data}.
REQ-011 SHALL have MAX_WAIT  output  WAIT_W  registered maximum of all wait counters.

Function
REQ-012 SHALL treat requester i as active only when REQ_VALID[i]=1, REQ_TAG[i]!=INVALID and FLUSH=0.
REQ-013 SHALL assert at most one GRANT bit per cycle: 0 when no requester is active.
REQ-014 SHALL select the winner round-robin: first active index at or after pointer PTR, searching upward with wrap NUM_REQ-1 -> 0.
REQ-015 SHALL, on a grant to index w, load PTR with (w+1) mod NUM_REQ at the next edge: PTR holds when there is no grant.
REQ-016 SHALL, on a grant to w, register CDB_OUT <= {REQ_TAG[w], REQ_DATA[w]} at the next edge, giving a latency of 1 cycle.
REQ-017 SHALL register CDB_OUT <= {INVALID, 32'h0} at the next edge when no grant occurs.
REQ-018 Handshake: a requester SHALL hold its REQ_VALID, REQ_TAG and REQ_DATA stable until it sees GRANT=1, and SHALL deassert or present a new result in the following cycle.
REQ-019 SHALL sample the inputs only at the edge: a REQ_VALID deasserted before GRANT is a withdrawn request with no broadcast.
REQ-020 Wait counter i SHALL increment, saturating at 2^WAIT_W-1, when requester i is active and not granted, and SHALL clear on grant or when the requester is inactive.
REQ-021 FLUSH=1 SHALL force GRANT=0, leave PTR unchanged, clear all wait counters, and give CDB_OUT tag INVALID at the next edge.
REQ-022 With all NUM_REQ requesters continuously active, each SHALL be granted exactly once in every NUM_REQ consecutive cycles, so MAX_WAIT never exceeds NUM_REQ-1.
REQ-023 A single active requester SHALL be granted in the same cycle regardless of PTR.

Reset
REQ-024 RST_N=0 SHALL immediately force CDB_OUT={INVALID, 0}, PTR=0, all wait counters=0, MAX_WAIT=0.
REQ-025 GRANT SHALL be 0 while RST_N=0.
REQ-026 Reset asserted mid-operation SHALL discard a granted-but-unregistered result: the requester sees GRANT only if RST_N=1 at the edge.
REQ-027 The first edge after RST_N rises SHALL arbitrate normally with PTR=0.

Structure
REQ-028 RS_tag_type (including INVALID), cdb_t and the constant NUM_CDB_REQ=4 SHALL live in the shared package cpu_types: no local redefinition.
REQ-029 The combinational one-hot round-robin picker SHALL be a sub-module rr_picker (inputs: active vector and PTR; output: one-hot grant).
REQ-030 PTR, the wait counters, MAX_WAIT and CDB_OUT SHALL be the only state in cdb_arbiter.

Verification
REQ-031 Reset, then REQ_VALID=4'b0100, tag T5, data 32'hDEAD_BEEF -> GRANT=4'b0100 the same cycle, CDB_OUT={T5, DEADBEEF} next cycle, PTR=3.
REQ-032 REQ_VALID=4'b1111 held for 8 cycles from PTR=0 -> grant order 0,1,2,3,0,1,2,3 and MAX_WAIT=3.
REQ-033 PTR=3, REQ_VALID=4'b1001 -> grant index 3, then 0 (wrap), then PTR=1.
REQ-034 REQ_VALID=4'b0011 with FLUSH=1 for one cycle -> GRANT=0, CDB_OUT tag INVALID, PTR unchanged, and the grant resumes on the following cycle.
REQ-035 REQ_VALID[1]=1 with REQ_TAG[1]=INVALID -> no grant, CDB_OUT tag INVALID, wait counter 1 stays 0.
REQ-036 RST_N pulled low mid-stream with 4'b1111 active -> CDB_OUT goes INVALID asynchronously, and the first grant after release goes to index 0.
